// File: rtl/osd_glyph_scheduler.sv
// osd_glyph_scheduler: shares one registered glyph ROM across all status-line
// slots, filling a double-buffered column store once per frame request.
// Optional build macro OSD_CHANGE_DETECT_EN skips the fill (done still pulses)
// when the latched codes match those of the last completed fill.
module osd_glyph_scheduler #(
   parameter int unsigned NSLOT  = 10,
   parameter int unsigned COLS   = 7,
   parameter int unsigned CODE_W = 6
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      frame_start,
   input  logic [NSLOT*CODE_W-1:0]   slot_codes,
   output logic [CODE_W-1:0]         rom_code,
   output logic [2:0]                rom_col,
   input  logic [7:0]                rom_data,
   input  logic [6:0]                rd_x,
   input  logic [2:0]                rd_y,
   output logic                      rd_pix,
   output logic                      busy,
   output logic                      done
);

   localparam int unsigned NPIX   = NSLOT * COLS;
   localparam int unsigned SLOT_W = (NSLOT > 1) ? $clog2(NSLOT) : 1;
   localparam int unsigned ADDR_W = 7;

   typedef enum logic [2:0] {IDLE, LATCH, FETCH, DRAIN, SWAP} state_t;

   state_t              state;
   logic [CODE_W-1:0]   snap [NSLOT];
   logic [SLOT_W-1:0]   slot;
   logic [2:0]          col;
   logic                pending;
   logic                front_sel;
   logic                cap_valid;
   logic [ADDR_W-1:0]   cap_addr;
   logic [7:0]          bank0 [NPIX];
   logic [7:0]          bank1 [NPIX];
   logic                last_issue;

`ifdef OSD_CHANGE_DETECT_EN
   logic [NSLOT*CODE_W-1:0] snap_pk;
   logic [NSLOT*CODE_W-1:0] last_snap;
   logic                    filled_once;
   logic                    skip_q;
`endif

   // Final issue of the fill: last column of the last slot
   assign last_issue = (slot == SLOT_W'(NSLOT - 1)) && (col == 3'(COLS - 1));

   // Fill sequencer: snapshot, ROM issue, capture tracking, bank swap
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         for (int i = 0; i < NSLOT; i++) snap[i] <= '0;
         slot      <= '0;
         col       <= '0;
         pending   <= 1'b0;
         front_sel <= 1'b0;
         cap_valid <= 1'b0;
         cap_addr  <= '0;
         rom_code  <= '0;
         rom_col   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
`ifdef OSD_CHANGE_DETECT_EN
         snap_pk     <= '0;
         last_snap   <= '0;
         filled_once <= 1'b0;
         skip_q      <= 1'b0;
`endif
      end else begin
         done      <= 1'b0;
         cap_valid <= 1'b0;

         // One-deep request memory; requests during a fill merge
         if (state == LATCH)
            pending <= frame_start;
         else if (state != IDLE && frame_start)
            pending <= 1'b1;

         case (state)
            IDLE: begin
               if (frame_start || pending) begin
                  state <= LATCH;
                  busy  <= 1'b1;
`ifdef OSD_CHANGE_DETECT_EN
                  // Skip decision is taken on the request cycle so done can
                  // be high during the LATCH cycle itself
                  skip_q <= filled_once && (slot_codes == last_snap);
                  done   <= filled_once && (slot_codes == last_snap);
`endif
               end
            end

            LATCH: begin
               for (int i = 0; i < NSLOT; i++)
                  snap[i] <= slot_codes[i*CODE_W +: CODE_W];
               slot <= '0;
               col  <= '0;
`ifdef OSD_CHANGE_DETECT_EN
               snap_pk <= slot_codes;
               if (skip_q) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  state    <= FETCH;
                  rom_code <= slot_codes[CODE_W-1:0];
                  rom_col  <= 3'd0;
               end
`else
               state    <= FETCH;
               rom_code <= slot_codes[CODE_W-1:0];
               rom_col  <= 3'd0;
`endif
            end

            FETCH: begin
               cap_valid <= 1'b1;
               cap_addr  <= ADDR_W'(slot) * ADDR_W'(COLS) + ADDR_W'(col);
               if (last_issue) begin
                  state    <= DRAIN;
                  rom_code <= '0;
                  rom_col  <= 3'd0;
               end else if (col == 3'(COLS - 1)) begin
                  slot     <= slot + SLOT_W'(1);
                  col      <= 3'd0;
                  rom_code <= snap[slot + SLOT_W'(1)];
                  rom_col  <= 3'd0;
               end else begin
                  col     <= col + 3'd1;
                  rom_col <= col + 3'd1;
               end
            end

            DRAIN: begin
               state <= SWAP;
               done  <= 1'b1;
            end

            SWAP: begin
               state     <= IDLE;
               busy      <= 1'b0;
               front_sel <= ~front_sel;
`ifdef OSD_CHANGE_DETECT_EN
               last_snap   <= snap_pk;
               filled_once <= 1'b1;
`endif
            end

            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // Back-bank capture of the ROM column issued on the previous cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NPIX; i++) begin
            bank0[i] <= '0;
            bank1[i] <= '0;
         end
      end else if (cap_valid) begin
         if (front_sel)
            bank0[cap_addr] <= rom_data;
         else
            bank1[cap_addr] <= rom_data;
      end
   end

   // Registered pixel read from the front bank; out-of-range columns read 0
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         rd_pix <= 1'b0;
      else if (rd_x < ADDR_W'(NPIX))
         rd_pix <= front_sel ? bank1[rd_x][rd_y] : bank0[rd_x][rd_y];
      else
         rd_pix <= 1'b0;
   end

endmodule

// File: tb/tb_osd_glyph_scheduler.sv
// Directed bench for osd_glyph_scheduler with a registered XOR glyph ROM model.
module tb_osd_glyph_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic        frame_start;
   logic [59:0] slot_codes;
   logic [5:0]  rom_code;
   logic [2:0]  rom_col;
   logic [7:0]  rom_data;
   logic [6:0]  rd_x;
   logic [2:0]  rd_y;
   logic        rd_pix;
   logic        busy;
   logic        done;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int done_cnt = 0;
   int done_at  = -1;

   osd_glyph_scheduler dut (
      .clk(clk), .rst(rst), .frame_start(frame_start), .slot_codes(slot_codes),
      .rom_code(rom_code), .rom_col(rom_col), .rom_data(rom_data),
      .rd_x(rd_x), .rd_y(rd_y), .rd_pix(rd_pix), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Registered ROM: column bits = code XOR column index, one cycle latency
   always @(posedge clk) rom_data <= {2'b00, rom_code} ^ {5'b0, rom_col};

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (done === 1'b1) begin
         done_cnt = done_cnt + 1;
         done_at  = cyc;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse();
      frame_start = 1'b1;
      step(1);
      frame_start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int start;
      start = done_cnt;
      for (int i = 0; i < budget && done_cnt == start; i++) step(1);
      check("done_seen", 32'(done_cnt != start), 32'd1);
   endtask

   function automatic logic [59:0] pack_all(input logic [5:0] c);
      logic [59:0] v;
      for (int s = 0; s < 10; s++) v[s*6 +: 6] = c;
      return v;
   endfunction

   function automatic logic [7:0] exp_col(input logic [59:0] codes, input int x);
      int s;
      int c;
      s = x / 7;
      c = x % 7;
      return {2'b00, codes[s*6 +: 6]} ^ 8'(c);
   endfunction

   task automatic read_col(input int x, output logic [7:0] b);
      for (int y = 0; y < 8; y++) begin
         rd_x = 7'(x);
         rd_y = 3'(y);
         step(1);
         b[y] = rd_pix;
      end
   endtask

   task automatic check_col(input string tag, input int x, input logic [7:0] exp);
      logic [7:0] b;
      read_col(x, b);
      check($sformatf("%s_col%0d", tag, x), 32'(b), 32'(exp));
   endtask

   task automatic check_bank(input string tag, input logic zero, input logic [59:0] codes);
      for (int x = 0; x < 70; x++)
         check_col(tag, x, zero ? 8'h00 : exp_col(codes, x));
   endtask

   initial begin
      int t0;
      int t2;
      logic [2:0] col_or;
      logic [59:0] codes_a;
      logic [59:0] codes_b;
      logic [59:0] codes_c;

      for (int s = 0; s < 10; s++) begin
         codes_a[s*6 +: 6] = 6'(s * 5 + 1);
         codes_b[s*6 +: 6] = 6'(63 - s);
      end
      codes_c = pack_all(6'h11);

      rst = 1'b0;
      frame_start = 1'b0;
      slot_codes = '0;
      rd_x = '0;
      rd_y = '0;
      step(3);

      // Reset values
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_rom_code", 32'(rom_code), 32'd0);
      check("rst_rom_col", 32'(rom_col), 32'd0);
      check("rst_rd_pix", 32'(rd_pix), 32'd0);
      rst = 1'b1;
      step(2);

      // Idle after reset: front bank all zero, no done
      check_bank("idle", 1'b1, '0);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_no_done", 32'(done_cnt), 32'd0);

      // Single fill with uniform codes
      slot_codes = pack_all(6'h05);
      t0 = cyc;
      pulse();
      check("latch_busy", 32'(busy), 32'd1);
      check("latch_rom_col", 32'(rom_col), 32'd0);
      step(1);
      check("first_issue_code", 32'(rom_code), 32'h05);
      check("first_issue_col", 32'(rom_col), 32'd0);
      step(3);
      check("issue_col3", 32'(rom_col), 32'd3);
      wait_done(200);
      check("fill1_done_at", 32'(done_at - t0), 32'd73);
      check("fill1_busy_after", 32'(busy), 32'd0);
      check("fill1_done_single", 32'(done), 32'd0);
      check_col("fill1", 3, 8'h06);
      check_col("fill1", 69, 8'h05 ^ 8'h06);
      check_col("fill1", 12, exp_col(slot_codes, 12));

      // Pending request plus snapshot isolation
      slot_codes = codes_a;
      t0 = cyc;
      pulse();
      step(9);
      slot_codes = codes_b;
      step(10);
      pulse();
      wait_done(100);
      check("fill2_done_at", 32'(done_at - t0), 32'd73);
      check_col("fill2_old", 0, exp_col(codes_a, 0));
      check_col("fill2_old", 5, exp_col(codes_a, 5));
      check_col("fill2_old", 69, exp_col(codes_a, 69));
      check("fill3_busy", 32'(busy), 32'd1);
      wait_done(100);
      check("fill3_done_at", 32'(done_at - t0), 32'd147);
      check_bank("fill3", 1'b0, codes_b);

      // Out-of-range read columns
      rd_x = 7'd0; rd_y = 3'd0;
      step(1);
      check("rd_in_range", 32'(rd_pix), 32'd1);
      rd_x = 7'd70; rd_y = 3'd0;
      step(1);
      check("rd_x70", 32'(rd_pix), 32'd0);
      rd_x = 7'd0; rd_y = 3'd1;
      step(1);
      check("rd_in_range2", 32'(rd_pix), 32'd1);
      rd_x = 7'd127; rd_y = 3'd7;
      step(1);
      check("rd_x127", 32'(rd_pix), 32'd0);

      // Reset during a fill
      slot_codes = codes_a;
      t0 = cyc;
      pulse();
      step(39);
      rst = 1'b0;
      #1;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_rom_code", 32'(rom_code), 32'd0);
      check("midrst_rom_col", 32'(rom_col), 32'd0);
      step(2);
      rst = 1'b1;
      t2 = done_cnt;
      step(80);
      check("midrst_no_done", 32'(done_cnt), 32'(t2));
      check("midrst_idle", 32'(busy), 32'd0);
      check_bank("midrst", 1'b1, '0);

      // Repeated identical codes
      slot_codes = codes_c;
      t0 = cyc;
      pulse();
      wait_done(200);
      check("same1_done_at", 32'(done_at - t0), 32'd73);
      step(2);
      t2 = cyc;
      pulse();
`ifdef OSD_CHANGE_DETECT_EN
      check("skip_done_latch", 32'(done), 32'd1);
      check("skip_busy_latch", 32'(busy), 32'd1);
      col_or = '0;
      for (int i = 0; i < 80; i++) begin
         step(1);
         col_or = col_or | rom_col;
      end
      check("skip_done_at", 32'(done_at - t2), 32'd1);
      check("skip_rom_quiet", 32'(col_or), 32'd0);
      check("skip_busy", 32'(busy), 32'd0);
      check_col("skip", 0, exp_col(codes_c, 0));
      check_col("skip", 69, exp_col(codes_c, 69));
`else
      col_or = '0;
      check("full_busy_latch", 32'(busy), 32'd1);
      for (int i = 0; i < 4; i++) begin
         step(1);
         col_or = col_or | rom_col;
      end
      check("full_rom_active", 32'(col_or), 32'd3);
      wait_done(200);
      check("same2_done_at", 32'(done_at - t2), 32'd73);
      check_col("same2", 0, exp_col(codes_c, 0));
      check_col("same2", 69, exp_col(codes_c, 69));
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/osd_glyph_scheduler.md
# osd_glyph_scheduler

Time-multiplexes one registered glyph ROM (char_set-style: 6-bit code in, 8-bit column out, one-cycle latency) across all character slots of the on-screen status line, replacing one ROM instance per slot. On each frame request it snapshots the slot codes, fetches every glyph column into a double-buffered column store, and then swaps banks so the pixel path always reads a complete, tear-free line. Sits between the mode/state/mileage formatters and the VGA pixel generator.

## Interface
- NSLOT, 10, number of character slots
- COLS, 7, columns per glyph
- CODE_W, 6, glyph code width
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- frame_start  in  1  single-cycle fill request (from vertical-blank start)
- slot_codes  in  NSLOT*CODE_W  slot codes; slot 0 in LSBs
- rom_code  out  CODE_W  glyph code to ROM
- rom_col  out  3  column index to ROM, 0..COLS-1
- rom_data  in  8  ROM column bits, valid the cycle after rom_code/rom_col; bit k = row k
- rd_x  in  7  display column, 0..NSLOT*COLS-1
- rd_y  in  3  display row, 0..7
- rd_pix  out  1  pixel from front bank, registered
- busy  out  1  fill in progress
- done  out  1  one-cycle pulse on bank swap

## Operation
- States: IDLE, LATCH, FETCH, DRAIN, SWAP.
- IDLE: on frame_start (or pending flag set) -> LATCH.
- LATCH (1 cycle): register slot_codes into snapshot; slot=0, col=0; clear pending.
- FETCH: each cycle drive rom_code=snapshot[slot], rom_col=col; advance col 0..COLS-1, then slot+1, col=0. After issuing slot NSLOT-1 col COLS-1 -> DRAIN.
- Capture pipeline: issue index delayed one cycle; rom_data written to back bank at address slot*COLS+col of the previous cycle.
- DRAIN (1 cycle): captures final column.
- SWAP (1 cycle): toggle front-bank select, pulse done -> IDLE.
- busy=1 in LATCH, FETCH, DRAIN, SWAP.
- rd_pix = front[rd_x][rd_y], registered; rd_x >= NSLOT*COLS -> 0.
- Outside FETCH, rom_code=0, rom_col=0.

## Timing
- Reset: state IDLE, both banks all-zero, front select=0, pending=0, rom_code=0, rom_col=0, rd_pix=0, busy=0, done=0.
- frame_start at cycle T (IDLE): LATCH T+1, first issue T+2, last issue T+1+NSLOT*COLS, DRAIN T+2+NSLOT*COLS, SWAP/done T+3+NSLOT*COLS (T+73 at defaults).
- frame_start while busy: sets pending (one deep; further requests merge); new fill begins the cycle after SWAP via LATCH.
- frame_start coincident with SWAP: counts as pending.
- slot_codes changes after LATCH do not affect the current fill.
- rd_pix latency 1 cycle from rd_x/rd_y; front bank changes only on the clock edge ending SWAP, so a read never mixes banks within one cycle.
- Reset asserted mid-fill: immediately aborts, returns to reset values; no done.

## Configuration
- OSD_CHANGE_DETECT_EN defined: in LATCH, if the new snapshot equals the snapshot of the last completed fill and at least one fill has completed since reset, skip FETCH/DRAIN/SWAP; go LATCH -> IDLE, pulse done in that cycle, no bank toggle, no ROM traffic.
- Undefined: every request performs a full fill and swap.

## Test plan
- Reset then idle: rd_pix=0 for all rd_x 0..69, rd_y 0..7; busy=0, done never pulses.
- ROM model rom_data={2'b0,code} XOR rom_col; slot_codes all 6'h05, pulse frame_start at T -> done at T+73, front column 3 = 8'h06, column 69 = 8'h05 XOR 6.
- frame_start at T, second pulse at T+20, codes changed at T+10 -> first fill uses T+1 codes; second fill starts T+74, done at T+147 with new codes.
- rd_x=70 or 127, any rd_y -> rd_pix=0 one cycle later.
- Assert rst at T+40 during fill -> busy=0, done absent, front bank still all-zero.
- With OSD_CHANGE_DETECT_EN: two fills with identical codes -> second gives done at T+1, rom_col stays 0, front select unchanged; without macro second takes 73 cycles and toggles banks.
